// File: rtl/spi_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// spi_cfg_sequencer_if
//   Bundles the request handshake, the SPI pins and the status outputs of the
//   SPI configuration sequencer so they can be passed as a single port.
//
//   Signals
//     req_valid  requester -> sequencer  write request valid
//     req_ready  sequencer -> requester  request FIFO can accept (= !full)
//     req_addr   requester -> sequencer  7-bit peripheral register address
//     req_data   requester -> sequencer  8-bit register write data
//     SCLK       sequencer -> peripheral SPI clock, mode 0 (idle low)
//     COPI       sequencer -> peripheral SPI data
//     nCS        sequencer -> peripheral SPI chip select, active low
//     busy       sequencer status        frame in progress or FIFO not empty
//     done       sequencer status        one-cycle pulse as nCS rises
//     frame_cnt  sequencer status        completed frames, wraps 255 -> 0
//     err_addr   sequencer status        one-cycle pulse on rejected address
//
//   Modports
//     master  requester / bench side (drives the request fields)
//     slave   sequencer side
// -----------------------------------------------------------------------------
interface spi_cfg_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       SCLK;
  logic       COPI;
  logic       nCS;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;
  logic       err_addr;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, SCLK, COPI, nCS, busy, done, frame_cnt, err_addr
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, SCLK, COPI, nCS, busy, done, frame_cnt, err_addr
  );
endinterface

// File: rtl/spi_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cfg_sequencer
//   SPI master that configures the SPI register peripheral. Register-write
//   requests arrive over a valid/ready port, are buffered in a small FIFO and
//   each one is sent as a 16-bit mode-0 write frame {1'b1, addr[6:0], data[7:0]},
//   MSB first, on SCLK/COPI/nCS.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous, active-low reset (aborts any frame in flight)
//     bus    spi_cfg_sequencer_if.slave: request handshake, SPI pins, status
//
//   Parameters
//     CLK_DIV     clk cycles per SCLK half-period (>= 2)
//     FIFO_DEPTH  request FIFO entries (power of 2, >= 2)
//     GAP_CYCLES  minimum clk cycles nCS is held high between frames (>= 1)
//     MAX_ADDR    highest accepted register address (0..127), only used when
//                 address checking is compiled in
//
//   Build option
//     SPI_SEQ_ADDR_CHECK_EN  when defined, requests with req_addr > MAX_ADDR
//                            are handshaked but dropped, and err_addr pulses
//                            in the accept cycle. Undefined: every request is
//                            sent and err_addr is tied low.
//
//   Frame timing (nCS low for exactly 33*CLK_DIV cycles)
//     SETUP  1 half-period with SCLK low, bit15 already on COPI
//     SHIFT  16 high half-periods and 15 low half-periods in between;
//            COPI advances on each falling edge
//     HOLD   1 final low half-period, then nCS rises with a done pulse
//     GAP    nCS high for GAP_CYCLES cycles before IDLE may pop again
// -----------------------------------------------------------------------------
module spi_cfg_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_ADDR   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_cfg_sequencer_if.slave  bus
);

`ifdef SPI_SEQ_ADDR_CHECK_EN
  localparam bit ADDR_CHECK_EN = 1'b1;
`else
  localparam bit ADDR_CHECK_EN = 1'b0;
`endif

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] DIV_LAST  = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [4:0]       LAST_RISE = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [14:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_ready;
  logic             w_accept;
  logic             w_addr_ok;
  logic             w_push;
  logic             w_pop;
  logic [14:0]      w_head;

  state_t           r_state;

  // Ready comes straight from the registered count, so a pop in the same cycle
  // never opens a slot for a push while the FIFO is full.
  assign w_ready   = (r_count != CNT_FULL);
  assign w_accept  = bus.req_valid && w_ready;

  // With checking compiled out the comparison is masked and every accepted
  // request is enqueued.
  assign w_addr_ok = !ADDR_CHECK_EN || (bus.req_addr <= 7'(MAX_ADDR));
  assign w_push    = w_accept && w_addr_ok;

  // The sequencer only ever takes a new request while idle.
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; entries are only read once the
  // registered count says they were written, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.req_addr, bus.req_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  logic [TMR_W-1:0] r_tmr;        // cycles spent in the current half-period/gap
  logic [4:0]       r_rise_cnt;   // SCLK rising edges issued in this frame
  logic [15:0]      r_shift;      // COPI is always the MSB of this register
  logic             r_sclk;
  logic             r_ncs;
  logic             r_done;
  logic [7:0]       r_frame_cnt;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the values from before the edge, whatever the statement
  // order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_rise_cnt  <= '0;
      r_shift     <= '0;
      r_sclk      <= 1'b0;
      r_ncs       <= 1'b1;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_tmr <= '0;
          if (r_count != '0) begin
            // Loading the frame puts bit15 on COPI as nCS falls.
            r_shift    <= {1'b1, w_head};
            r_ncs      <= 1'b0;
            r_rise_cnt <= '0;
            r_state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (r_tmr == DIV_LAST) begin
            r_tmr      <= '0;
            r_sclk     <= 1'b1;
            r_rise_cnt <= 5'd1;
            r_state    <= S_SHIFT;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end

        S_SHIFT: begin
          if (r_tmr == DIV_LAST) begin
            r_tmr <= '0;
            if (r_sclk) begin
              // Falling edge: the peripheral has sampled, so present the next
              // bit while SCLK is low. After the 16th rise bit0 stays put.
              r_sclk <= 1'b0;
              if (r_rise_cnt == LAST_RISE) begin
                r_state <= S_HOLD;
              end else begin
                r_shift <= {r_shift[14:0], 1'b0};
              end
            end else begin
              r_sclk     <= 1'b1;
              r_rise_cnt <= r_rise_cnt + 5'd1;
            end
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end

        S_HOLD: begin
          if (r_tmr == DIV_LAST) begin
            r_tmr       <= '0;
            r_ncs       <= 1'b1;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_state     <= S_GAP;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end

        S_GAP: begin
          if (r_tmr == GAP_LAST) begin
            r_tmr   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end

        default: begin
          r_tmr   <= '0;
          r_sclk  <= 1'b0;
          r_ncs   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready = w_ready;
  assign bus.SCLK      = r_sclk;
  assign bus.COPI      = r_shift[15];
  assign bus.nCS       = r_ncs;
  assign bus.done      = r_done;
  assign bus.frame_cnt = r_frame_cnt;
  // Both terms are registers, so busy drops the cycle after GAP hands back to
  // IDLE with nothing queued.
  assign bus.busy      = (r_state != S_IDLE) || (r_count != '0);
  // Flags the request in the very cycle it is handshaked.
  assign bus.err_addr  = w_accept && !w_addr_ok;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_cfg_sequencer
//   Self-checking bench for spi_cfg_sequencer. A passive SPI receiver decodes
//   every frame from the pins (bits at SCLK rising edges, nCS low time, gap
//   before the frame, done alignment); the reference model is a queue of the
//   16-bit words the specification says each accepted request must produce.
//   Honours SPI_SEQ_ADDR_CHECK_EN when the same macro is defined for the bench.
// -----------------------------------------------------------------------------
module tb_spi_cfg_sequencer;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 4;
  localparam int MAX_ADDR   = 4;
  localparam int FRAME_LOW  = 33 * CLK_DIV;

`ifdef SPI_SEQ_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  spi_cfg_sequencer_if bus ();

  spi_cfg_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_CYCLES (GAP_CYCLES),
    .MAX_ADDR   (MAX_ADDR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Passive SPI receiver
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] bits;
    int          rises;
    int          low_len;
    logic        done_at_end;
  } frame_t;

  frame_t frames_q[$];
  int     gap_q[$];
  int     done_cnt = 0;

  initial begin : monitor
    logic        prev_sclk;
    logic        prev_ncs;
    logic        in_frame;
    logic        have_prev;
    logic [15:0] sh;
    int          rises;
    int          low_len;
    int          gap_len;
    prev_sclk = 1'b0;
    prev_ncs  = 1'b1;
    in_frame  = 1'b0;
    have_prev = 1'b0;
    sh        = '0;
    rises     = 0;
    low_len   = 0;
    gap_len   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        // An aborted frame is discarded and the next one starts fresh.
        prev_sclk = 1'b0;
        prev_ncs  = 1'b1;
        in_frame  = 1'b0;
        have_prev = 1'b0;
        gap_len   = 0;
      end else begin
        if (!bus.nCS) begin
          if (prev_ncs) begin
            if (have_prev) gap_q.push_back(gap_len);
            in_frame = 1'b1;
            sh       = '0;
            rises    = 0;
            low_len  = 0;
          end
          low_len++;
          if (bus.SCLK && !prev_sclk) begin
            sh = {sh[14:0], bus.COPI};
            rises++;
          end
        end else begin
          if (!prev_ncs && in_frame) begin
            frames_q.push_back('{bits: sh, rises: rises, low_len: low_len,
                                 done_at_end: bus.done});
            in_frame  = 1'b0;
            have_prev = 1'b1;
            gap_len   = 0;
          end
          gap_len++;
        end
        if (bus.done) done_cnt++;
        prev_sclk = bus.SCLK;
        prev_ncs  = bus.nCS;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: expected frame words, and accepted requests since reset
  // ---------------------------------------------------------------------------
  logic [15:0] exp_q[$];
  int          n_sent = 0;

  // Present a request at a falling edge and hold it until it is handshaked.
  // Returns at the falling edge after the accepting rising edge with valid
  // still high, so consecutive calls issue back-to-back requests.
  task automatic push_req(input logic [6:0] a, input logic [7:0] d, output bit ready_first);
    int waitc;
    bit ok;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    #1;
    ready_first = bus.req_ready;
    waitc = 0;
    while (!bus.req_ready && waitc < 5000) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!bus.req_ready) begin
      check("push_timeout", 32'(bus.req_ready), 32'd1);
    end else begin
      ok = !CHECK_EN || (int'(a) <= MAX_ADDR);
      check("err_addr", 32'(bus.err_addr), 32'(!ok));
      if (ok) begin
        exp_q.push_back({1'b1, a, d});
        n_sent++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int c;
    bus.req_valid = 1'b0;
    c = 0;
    while (bus.busy && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check("idle_reached", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Compare every decoded frame against the model, in order.
  task automatic drain_check();
    frame_t      f;
    logic [15:0] e;
    int          g;
    while (exp_q.size() > 0) begin
      if (frames_q.size() == 0) begin
        check("frame_missing", 32'(frames_q.size()), 32'(exp_q.size()));
        exp_q.delete();
        break;
      end
      f = frames_q.pop_front();
      e = exp_q.pop_front();
      check("frame_bits", 32'(f.bits), 32'(e));
      check("frame_rises", 32'(f.rises), 32'd16);
      check("ncs_low_len", 32'(f.low_len), 32'(FRAME_LOW));
      check("done_at_ncs_rise", 32'(f.done_at_end), 32'd1);
    end
    check("extra_frames", 32'(frames_q.size()), 32'd0);
    frames_q.delete();
    while (gap_q.size() > 0) begin
      g = gap_q.pop_front();
      check("gap_ge_min", 32'(g >= GAP_CYCLES), 32'd1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit rf;
    bit rdy [6];
    int done_base;
    int r;
    int c;
    logic ps;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ncs",       32'(bus.nCS),       32'd1);
    check("rst_sclk",      32'(bus.SCLK),      32'd0);
    check("rst_copi",      32'(bus.COPI),      32'd0);
    check("rst_ready",     32'(bus.req_ready), 32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check("rst_err_addr",  32'(bus.err_addr),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write 0x00/0xA5, with start latency
    push_req(7'h00, 8'hA5, rf);
    bus.req_valid = 1'b0;
    check("latency_ncs_before", 32'(bus.nCS), 32'd1);
    @(negedge clk);
    check("latency_ncs_low", 32'(bus.nCS), 32'd0);
    check("busy_in_frame", 32'(bus.busy), 32'd1);
    wait_idle();
    drain_check();
    check("t1_frame_cnt", 32'(bus.frame_cnt), 32'(n_sent & 8'hFF));

    // Burst of six back-to-back requests into an empty FIFO
    for (int i = 0; i < 6; i++) begin
      push_req(7'($urandom_range(0, MAX_ADDR)), 8'($urandom), rf);
      rdy[i] = rf;
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("burst_ready_%0d", i), 32'(rdy[i]), 32'(i < FIFO_DEPTH + 1));
    end
    wait_idle();
    drain_check();
    check("t2_frame_cnt", 32'(bus.frame_cnt), 32'(n_sent & 8'hFF));

    // Reset after the 7th SCLK rise of a frame with two more queued
    for (int i = 0; i < 3; i++) begin
      push_req(7'($urandom_range(0, MAX_ADDR)), 8'($urandom), rf);
    end
    bus.req_valid = 1'b0;
    r  = 0;
    c  = 0;
    ps = bus.SCLK;
    while (r < 7 && c < 2000) begin
      @(negedge clk);
      if (bus.SCLK && !ps) r++;
      ps = bus.SCLK;
      c++;
    end
    check("t3_rises_reached", 32'(r), 32'd7);
    #1 rst_n = 1'b0;
    #1;
    check("t3_ncs",       32'(bus.nCS),       32'd1);
    check("t3_sclk",      32'(bus.SCLK),      32'd0);
    check("t3_done",      32'(bus.done),      32'd0);
    check("t3_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check("t3_busy",      32'(bus.busy),      32'd0);
    check("t3_ready",     32'(bus.req_ready), 32'd1);
    exp_q.delete();
    n_sent = 0;
    repeat (2) @(negedge clk);
    done_base = done_cnt;
    frames_q.delete();
    gap_q.delete();
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("t3_no_frames", 32'(frames_q.size()), 32'd0);
    check("t3_no_done",   32'(done_cnt - done_base), 32'd0);
    check("t3_ncs_idle",  32'(bus.nCS), 32'd1);

    // Address above MAX_ADDR
    push_req(7'd5, 8'h3C, rf);
    bus.req_valid = 1'b0;
    if (CHECK_EN) begin
      repeat (20) @(negedge clk);
      check("t4_ncs_idle", 32'(bus.nCS),  32'd1);
      check("t4_busy",     32'(bus.busy), 32'd0);
    end
    wait_idle();
    drain_check();
    check("t4_frame_cnt", 32'(bus.frame_cnt), 32'(n_sent & 8'hFF));

    // Peripheral configuration sequence
    push_req(7'd0, 8'h01, rf);
    push_req(7'd1, 8'h02, rf);
    push_req(7'd2, 8'h04, rf);
    push_req(7'd3, 8'h08, rf);
    push_req(7'd4, 8'h80, rf);
    wait_idle();
    drain_check();
    check("t6_frame_cnt", 32'(bus.frame_cnt), 32'(n_sent & 8'hFF));

    // Random traffic up to 255 frames since reset, then the wrap
    while (n_sent < 255) begin
      push_req(7'($urandom_range(0, 127)), 8'($urandom), rf);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    wait_idle();
    drain_check();
    check("cnt_255", 32'(bus.frame_cnt), 32'(n_sent & 8'hFF));

    push_req(7'($urandom_range(0, MAX_ADDR)), 8'($urandom), rf);
    wait_idle();
    drain_check();
    check("cnt_wrap_0", 32'(bus.frame_cnt), 32'(n_sent & 8'hFF));

    push_req(7'($urandom_range(0, MAX_ADDR)), 8'($urandom), rf);
    wait_idle();
    drain_check();
    check("cnt_wrap_1", 32'(bus.frame_cnt), 32'(n_sent & 8'hFF));
    check("done_pulses", 32'(done_cnt - done_base), 32'(n_sent));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
